// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port between writeback (always wins)
// and a valid/ready side requester, with a starvation counter that requests a pipeline bubble.
module regfile_wport_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_write,
  input  logic [2:0]  wb_writenum,
  input  logic [15:0] wb_data,
  input  logic        side_valid,
  input  logic [2:0]  side_num,
  input  logic [15:0] side_data,
  output logic        side_ready,
  output logic        rf_write,
  output logic [2:0]  rf_writenum,
  output logic [15:0] rf_data,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stall_req;
  logic             r_rf_write;
  logic [2:0]       r_rf_writenum;
  logic [15:0]      r_rf_data;
  logic             w_transfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= LP_CNT_MAX) return LP_CNT_MAX;
    return c + LP_CNT_ONE;
  endfunction

  // Grant is purely combinational: writeback is never blocked.
  assign w_transfer = side_valid & ~wb_write;
  assign side_ready = w_transfer;

  // Port register stage: address/data hold when no write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_write    <= 1'b0;
      r_rf_writenum <= 3'd0;
      r_rf_data     <= 16'd0;
    end else if (wb_write) begin
      r_rf_write    <= 1'b1;
      r_rf_writenum <= wb_writenum;
      r_rf_data     <= wb_data;
    end else if (w_transfer) begin
      r_rf_write    <= 1'b1;
      r_rf_writenum <= side_num;
      r_rf_data     <= side_data;
    end else begin
      r_rf_write    <= 1'b0;
    end
  end

  // Starvation FSM; a withdrawn side request returns to IDLE without any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stall_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_stall_req <= 1'b0;
          if (side_valid && wb_write) begin
            r_state <= WAIT;
            r_cnt   <= LP_CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (w_transfer || !side_valid) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_stall_req <= 1'b0;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_state     <= STALL;
            r_stall_req <= 1'b1;
          end else begin
            r_cnt       <= sat_inc(r_cnt);
          end
        end
        STALL: begin
          if (w_transfer || !side_valid) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_stall_req <= 1'b0;
          end else begin
            r_stall_req <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_stall_req <= 1'b0;
        end
      endcase
    end
  end

  assign rf_write    = r_rf_write;
  assign rf_writenum = r_rf_writenum;
  assign rf_data     = r_rf_data;
  assign stall_req   = r_stall_req;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scenario bench for regfile_wport_arbiter: expected port writes are queued at stimulus
// time and popped by a negedge monitor; control outputs are checked inline per scenario.
module tb_regfile_wport_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_write;
  logic [2:0]  wb_writenum;
  logic [15:0] wb_data;
  logic        side_valid;
  logic [2:0]  side_num;
  logic [15:0] side_data;
  logic        side_ready;
  logic        rf_write;
  logic [2:0]  rf_writenum;
  logic [15:0] rf_data;
  logic        stall_req;

  int n_pass  = 0;
  int n_total = 0;
  logic [18:0] sb[$];

  regfile_wport_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .wb_write(wb_write), .wb_writenum(wb_writenum), .wb_data(wb_data),
    .side_valid(side_valid), .side_num(side_num), .side_data(side_data),
    .side_ready(side_ready),
    .rf_write(rf_write), .rf_writenum(rf_writenum), .rf_data(rf_data),
    .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every issued write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && rf_write) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL spurious_write: got num=%0d data=%h, expected no write", rf_writenum, rf_data);
      end else begin
        logic [18:0] e;
        e = sb.pop_front();
        if ({rf_writenum, rf_data} !== e)
          $display("FAIL write_order: got num=%0d data=%h, expected num=%0d data=%h",
                   rf_writenum, rf_data, e[18:16], e[15:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_write = 1'b0; wb_writenum = 3'd0; wb_data = 16'd0;
    side_valid = 1'b0; side_num = 3'd0; side_data = 16'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    n_total++;
    if ({rf_write, rf_writenum, rf_data, stall_req} !== 21'd0)
      $display("FAIL reset_state: got we=%b num=%0d data=%h stall=%b, expected all 0",
               rf_write, rf_writenum, rf_data, stall_req);
    else n_pass++;
    cyc();
    rst = 1'b1;
    cyc();
    wb_write = 1'b1; wb_writenum = 3'd7; wb_data = 16'h5A5A;
    side_valid = 1'b1; side_num = 3'd1; side_data = 16'h1111;
    sb.push_back({3'd7, 16'h5A5A});
    cyc();
    n_total++;
    if (rf_write !== 1'b1) $display("FAIL pre_reset_write: got we=%b, expected 1", rf_write);
    else n_pass++;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if ({rf_write, rf_writenum, rf_data, stall_req} !== 21'd0)
      $display("FAIL async_reset: got we=%b num=%0d data=%h stall=%b, expected all 0",
               rf_write, rf_writenum, rf_data, stall_req);
    else n_pass++;
    cyc();
    idle_inputs();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_wb_only();
    wb_write = 1'b1; wb_writenum = 3'd5; wb_data = 16'h1234;
    sb.push_back({3'd5, 16'h1234});
    #1;
    n_total++;
    if (side_ready !== 1'b0) $display("FAIL wb_only_ready: got %b, expected 0", side_ready);
    else n_pass++;
    cyc();
    n_total++;
    if ({rf_write, rf_writenum, rf_data} !== {1'b1, 3'd5, 16'h1234})
      $display("FAIL wb_only_write: got we=%b num=%0d data=%h, expected 1/5/1234",
               rf_write, rf_writenum, rf_data);
    else n_pass++;
    wb_write = 1'b0;
    cyc();
    n_total++;
    if ({rf_write, rf_writenum, rf_data} !== {1'b0, 3'd5, 16'h1234})
      $display("FAIL wb_only_hold: got we=%b num=%0d data=%h, expected 0/5/1234",
               rf_write, rf_writenum, rf_data);
    else n_pass++;
  endtask

  task automatic test_free_port();
    side_valid = 1'b1; side_num = 3'd2; side_data = 16'hBEEF;
    sb.push_back({3'd2, 16'hBEEF});
    #1;
    n_total++;
    if (side_ready !== 1'b1) $display("FAIL free_ready: got %b, expected 1", side_ready);
    else n_pass++;
    cyc();
    side_valid = 1'b0;
    n_total++;
    if ({rf_write, rf_writenum, rf_data, stall_req} !== {1'b1, 3'd2, 16'hBEEF, 1'b0})
      $display("FAIL free_write: got we=%b num=%0d data=%h stall=%b, expected 1/2/beef/0",
               rf_write, rf_writenum, rf_data, stall_req);
    else n_pass++;
    cyc();
    n_total++;
    if (rf_write !== 1'b0) $display("FAIL free_single: got we=%b, expected 0", rf_write);
    else n_pass++;
  endtask

  task automatic test_starvation();
    side_valid = 1'b1; side_num = 3'd6; side_data = 16'hC0DE;
    wb_write = 1'b1; wb_writenum = 3'd1;
    for (int k = 0; k < 6; k++) begin
      wb_data = 16'(k + 16'h0100);
      sb.push_back({3'd1, 16'(k + 16'h0100)});
      #1;
      n_total++;
      if (side_ready !== 1'b0) $display("FAIL starve_ready_c%0d: got %b, expected 0", k, side_ready);
      else n_pass++;
      cyc();
      n_total++;
      if (stall_req !== (k + 1 >= 4))
        $display("FAIL starve_stall_e%0d: got %b, expected %b", k + 1, stall_req, (k + 1 >= 4));
      else n_pass++;
    end
    wb_write = 1'b0;
    sb.push_back({3'd6, 16'hC0DE});
    #1;
    n_total++;
    if (side_ready !== 1'b1) $display("FAIL starve_grant: got %b, expected 1", side_ready);
    else n_pass++;
    cyc();
    side_valid = 1'b0;
    n_total++;
    if ({stall_req, rf_write, rf_writenum, rf_data} !== {1'b0, 1'b1, 3'd6, 16'hC0DE})
      $display("FAIL starve_release: got stall=%b we=%b num=%0d data=%h, expected 0/1/6/c0de",
               stall_req, rf_write, rf_writenum, rf_data);
    else n_pass++;
    cyc();
  endtask

  task automatic test_collision();
    wb_write = 1'b1; wb_writenum = 3'd3; wb_data = 16'h0001;
    side_valid = 1'b1; side_num = 3'd3; side_data = 16'h0002;
    sb.push_back({3'd3, 16'h0001});
    cyc();
    wb_write = 1'b0;
    sb.push_back({3'd3, 16'h0002});
    cyc();
    side_valid = 1'b0;
    n_total++;
    if ({rf_writenum, rf_data} !== {3'd3, 16'h0002})
      $display("FAIL collision_final: got num=%0d data=%h, expected 3/0002", rf_writenum, rf_data);
    else n_pass++;
    cyc();
  endtask

  task automatic test_withdraw();
    side_valid = 1'b1; side_num = 3'd5; side_data = 16'h7777;
    wb_write = 1'b1; wb_writenum = 3'd4;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) side_valid = 1'b0;
      wb_data = 16'(16'h0200 + k);
      sb.push_back({3'd4, 16'(16'h0200 + k)});
      cyc();
      n_total++;
      if (stall_req !== 1'b0) $display("FAIL withdraw_stall_e%0d: got %b, expected 0", k + 1, stall_req);
      else n_pass++;
    end
    side_valid = 1'b1; side_num = 3'd0; side_data = 16'h9999;
    for (int k = 0; k < 4; k++) begin
      wb_data = 16'(16'h0300 + k);
      sb.push_back({3'd4, 16'(16'h0300 + k)});
      cyc();
      n_total++;
      if (stall_req !== (k == 3))
        $display("FAIL represent_stall_e%0d: got %b, expected %b", k + 1, stall_req, (k == 3));
      else n_pass++;
    end
    wb_write = 1'b0;
    sb.push_back({3'd0, 16'h9999});
    cyc();
    side_valid = 1'b0;
    cyc();
    n_total++;
    if (stall_req !== 1'b0) $display("FAIL represent_release: got %b, expected 0", stall_req);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_free_port();
    test_starvation();
    test_collision();
    test_withdraw();
    idle_inputs();
    cyc();
    cyc();
    n_total++;
    if (sb.size() !== 0) $display("FAIL missing_writes: got %0d pending, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
